// File: rtl/branch_resolve_unit_if.sv
// Branch request bus between the ID stage and the branch resolver.
// Master (ID stage) drives the branch and operands; slave returns stall_req.
interface branch_resolve_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic              br_valid;
    logic [2:0]        br_op;
    logic              opnd_ready;
    logic [WIDTH-1:0]  reg_s;
    logic [WIDTH-1:0]  reg_t;
    logic [ADDR_W-1:0] br_target;
    logic              stall_req;

    modport master (
        output br_valid, br_op, opnd_ready,
        output reg_s, reg_t, br_target,
        input  stall_req
    );

    modport slave (
        input  br_valid, br_op, opnd_ready,
        input  reg_s, reg_t, br_target,
        output stall_req
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver for ID: stalls until operands are forwarded,
// then emits a registered taken/redirect/flush result plus statistics.
// Ports: clk, rst_n (async, active-low), bus (branch request, slave),
//   cnt_clr (sync counter clear), res_valid/res_taken/flush/redirect_pc
//   (registered result), cnt_branch/cnt_taken (saturating counters).
module branch_resolve_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus,
    input  logic                 cnt_clr,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 flush,
    output logic [ADDR_W-1:0]    redirect_pc,
    output logic [CNT_W-1:0]     cnt_branch,
    output logic [CNT_W-1:0]     cnt_taken
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              res_valid_q, res_valid_d;
    logic              res_taken_q, res_taken_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;

    logic              resolve;
    logic [2:0]        use_op;
    logic [ADDR_W-1:0] use_tgt;
    logic              cond;
    logic              s_eq_t;
    logic              s_neg;
    logic              s_zero;

    assign s_eq_t = (bus.reg_s == bus.reg_t);
    assign s_neg  = bus.reg_s[WIDTH-1];
    assign s_zero = (bus.reg_s == '0);

    // Control: decide whether to resolve now, wait, and which op/target apply
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        tgt_d         = tgt_q;
        resolve       = 1'b0;
        use_op        = bus.br_op;
        use_tgt       = bus.br_target;
        bus.stall_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    if (bus.opnd_ready) begin
                        resolve = 1'b1;
                    end else begin
                        op_d          = bus.br_op;
                        tgt_d         = bus.br_target;
                        bus.stall_req = 1'b1;
                        state_d       = WAIT;
                    end
                end
            end
            WAIT: begin
                // br_valid is ignored: the front end is held on this branch
                use_op  = op_q;
                use_tgt = tgt_q;
                if (bus.opnd_ready) begin
                    resolve = 1'b1;
                    state_d = IDLE;
                end else begin
                    bus.stall_req = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Condition evaluation on the live operands
    always_comb begin
        cond = 1'b0;
        unique case (use_op)
            3'd0:    cond = s_eq_t;
            3'd1:    cond = !s_eq_t;
            3'd2:    cond = s_neg | s_zero;
            3'd3:    cond = !s_neg & !s_zero;
            3'd4:    cond = s_neg;
            3'd5:    cond = !s_neg;
            3'd6:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Result registers and saturating statistics
    always_comb begin
        res_valid_d  = resolve;
        res_taken_d  = resolve & cond;
        redirect_d   = (resolve & cond) ? use_tgt : redirect_q;
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        if (cnt_clr) begin
            cnt_branch_d = '0;
            cnt_taken_d  = '0;
        end else if (resolve) begin
            if (cnt_branch_q != CNT_MAX) cnt_branch_d = cnt_branch_q + 1'b1;
            if (cond && cnt_taken_q != CNT_MAX) cnt_taken_d = cnt_taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            tgt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            redirect_q   <= '0;
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            tgt_q        <= tgt_d;
            res_valid_q  <= res_valid_d;
            res_taken_q  <= res_taken_d;
            redirect_q   <= redirect_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_taken   = res_taken_q;
    assign flush       = res_taken_q;
    assign redirect_pc = redirect_q;
    assign cnt_branch  = cnt_branch_q;
    assign cnt_taken   = cnt_taken_q;

endmodule
